// File: rtl/unsigned_seq_divider.sv
// Iterative restoring radix-2 unsigned divider: one quotient bit per clock,
// valid/ready handshakes on operands and result, defined divide-by-zero result.
module unsigned_seq_divider #(
    parameter int DIVIDEND_W = 16,
    parameter int DIVISOR_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    localparam int CNT_W = $clog2(DIVIDEND_W) + 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DIVIDEND_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DIVIDEND_W-1:0]   q_q, q_d;
    logic [DIVISOR_W-1:0]    d_q, d_d;
    logic [DIVISOR_W:0]      r_q, r_d;
    logic                    zero_q, zero_d;
    logic [DIVIDEND_W-1:0]   quotient_q, quotient_d;
    logic [DIVISOR_W-1:0]    remainder_q, remainder_d;
    logic                    dbz_q, dbz_d;

    logic [DIVISOR_W:0]      shifted;
    logic [DIVISOR_W+1:0]    diff;
    logic                    borrow;
    logic [DIVISOR_W:0]      r_step;
    logic [DIVIDEND_W-1:0]   q_step;

    // One restoring step: trial subtract, keep the difference only without borrow.
    always_comb begin
        shifted = {r_q[DIVISOR_W-1:0], q_q[DIVIDEND_W-1]};
        diff    = {1'b0, shifted} - {2'b00, d_q};
        borrow  = diff[DIVISOR_W+1];
        r_step  = borrow ? shifted : diff[DIVISOR_W:0];
        q_step  = {q_q[DIVIDEND_W-2:0], ~borrow};
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        q_d         = q_q;
        d_d         = d_q;
        r_d         = r_q;
        zero_d      = zero_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    q_d     = dividend;
                    d_d     = divisor;
                    r_d     = '0;
                    cnt_d   = '0;
                    zero_d  = (divisor == '0);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // A zero divisor spends a single BUSY cycle so its result appears after accept+1.
                if (zero_q) begin
                    quotient_d  = '1;
                    remainder_d = '0;
                    dbz_d       = 1'b1;
                    state_d     = DONE;
                end else begin
                    q_d   = q_step;
                    r_d   = r_step;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_ITER) begin
                        quotient_d  = q_step;
                        remainder_d = r_step[DIVISOR_W-1:0];
                        dbz_d       = 1'b0;
                        state_d     = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            q_q         <= '0;
            d_q         <= '0;
            r_q         <= '0;
            zero_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            q_q         <= q_d;
            d_q         <= d_d;
            r_q         <= r_d;
            zero_q      <= zero_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule
